// File: rtl/ps2_key_pkg.sv
// Shared types and helpers for the PS/2 key sequencer: parser states, prefix
// scan codes, special key indices and the set-2 scan-code translation table.
package ps2_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [4:0] KEY_ENTER = 5'd26;
  localparam logic [4:0] KEY_BKSP  = 5'd27;

  // Returns {hit, idx}; hit=0 means the make code has no Enigma key.
  function automatic logic [5:0] scan_to_idx(input logic [7:0] scan);
    logic [5:0] res;
    case (scan)
      8'h1C:   res = {1'b1, 5'd0};
      8'h32:   res = {1'b1, 5'd1};
      8'h21:   res = {1'b1, 5'd2};
      8'h23:   res = {1'b1, 5'd3};
      8'h24:   res = {1'b1, 5'd4};
      8'h2B:   res = {1'b1, 5'd5};
      8'h34:   res = {1'b1, 5'd6};
      8'h33:   res = {1'b1, 5'd7};
      8'h43:   res = {1'b1, 5'd8};
      8'h3B:   res = {1'b1, 5'd9};
      8'h42:   res = {1'b1, 5'd10};
      8'h4B:   res = {1'b1, 5'd11};
      8'h3A:   res = {1'b1, 5'd12};
      8'h31:   res = {1'b1, 5'd13};
      8'h44:   res = {1'b1, 5'd14};
      8'h4D:   res = {1'b1, 5'd15};
      8'h15:   res = {1'b1, 5'd16};
      8'h2D:   res = {1'b1, 5'd17};
      8'h1B:   res = {1'b1, 5'd18};
      8'h2C:   res = {1'b1, 5'd19};
      8'h3C:   res = {1'b1, 5'd20};
      8'h2A:   res = {1'b1, 5'd21};
      8'h1D:   res = {1'b1, 5'd22};
      8'h22:   res = {1'b1, 5'd23};
      8'h35:   res = {1'b1, 5'd24};
      8'h1A:   res = {1'b1, 5'd25};
      8'h5A:   res = {1'b1, KEY_ENTER};
      8'h66:   res = {1'b1, KEY_BKSP};
      default: res = 6'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ps2_key_sequencer_key_fifo.sv
// Synchronous circular FIFO with occupancy count, sticky overflow and a
// registered head so the output word is a flop, not a memory read path.
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_ready,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_rd_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic [WIDTH-1:0] r_head;
  logic             r_overflow;

  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_drop;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = r_valid & i_rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok = i_wr_en & (~w_full | w_pop);
  assign w_drop    = i_wr_en & w_full & ~w_pop;

  // Next read pointer, occupancy and head word.
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    w_head_nxt   = {WIDTH{1'b0}};
    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + 1'b1;
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
    w_count_nxt = r_count + {{(CW-1){1'b0}}, w_push_ok} - {{(CW-1){1'b0}}, w_pop};
    if (w_count_nxt == {CW{1'b0}}) begin
      w_head_nxt = {WIDTH{1'b0}};
    end else if (w_push_ok && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_nxt = i_wr_data;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Storage array; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers, count, registered head/valid and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= {AW{1'b0}};
      r_wr_ptr   <= {AW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_valid    <= 1'b0;
      r_head     <= {WIDTH{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != {CW{1'b0}});
      r_head  <= w_head_nxt;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_rd_data  = r_head;
  assign o_rd_valid = r_valid;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_key_sequencer.sv
// Set-2 make/break parser translating key presses into Enigma key indices and
// buffering them in key_fifo. Define PS2_TYPEMATIC_FILTER_EN to suppress
// auto-repeat makes via a held-key mask cleared by the matching break.
module ps2_key_sequencer
  import ps2_key_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int TO_WIDTH       = 21
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_stb,
  output logic [4:0]                    key_idx,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  ps2_state_e          r_state;
  logic [TO_WIDTH-1:0] r_to_cnt;
  logic                r_push;
  logic [4:0]          r_push_idx;

  logic [5:0] w_lookup;
  logic       w_hit;
  logic [4:0] w_idx;
  logic       w_make_ok;

  assign w_lookup = scan_to_idx(byte_in);
  assign w_hit    = w_lookup[5];
  assign w_idx    = w_lookup[4:0];

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [27:0] r_held;

  assign w_make_ok = w_hit & ~r_held[w_idx];

  // Held-key mask: set on a translated make, cleared by the matching break.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_held <= 28'd0;
    end else if (byte_stb && w_hit) begin
      if (r_state == ST_IDLE) begin
        r_held[w_idx] <= 1'b1;
      end else if (r_state == ST_BRK) begin
        r_held[w_idx] <= 1'b0;
      end
    end
  end
`else
  assign w_make_ok = w_hit;
`endif

  // Parser FSM, prefix timeout and registered translation stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_to_cnt   <= {TO_WIDTH{1'b0}};
      r_push     <= 1'b0;
      r_push_idx <= 5'd0;
    end else begin
      r_push     <= 1'b0;
      r_push_idx <= w_idx;
      if (byte_stb) begin
        r_to_cnt <= {TO_WIDTH{1'b0}};
        case (r_state)
          ST_IDLE: begin
            if (byte_in == SC_EXT) begin
              r_state <= ST_EXT;
            end else if (byte_in == SC_BRK) begin
              r_state <= ST_BRK;
            end else begin
              r_state <= ST_IDLE;
              r_push  <= w_make_ok;
            end
          end
          ST_EXT: begin
            if (byte_in == SC_BRK) begin
              r_state <= ST_EXT_BRK;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_BRK:     r_state <= ST_IDLE;
          ST_EXT_BRK: r_state <= ST_IDLE;
          default:    r_state <= ST_IDLE;
        endcase
      end else if (r_state == ST_IDLE) begin
        r_to_cnt <= {TO_WIDTH{1'b0}};
      end else if (r_to_cnt == TO_LAST) begin
        // An abandoned prefix must not swallow the next make code.
        r_state  <= ST_IDLE;
        r_to_cnt <= {TO_WIDTH{1'b0}};
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (5)
  ) u_key_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (r_push),
    .i_wr_data  (r_push_idx),
    .i_rd_ready (key_ready),
    .o_rd_data  (key_idx),
    .o_rd_valid (key_valid),
    .o_count    (fifo_count),
    .o_overflow (overflow)
  );

endmodule
